// File: rtl/xarbiter_pkg.sv
// Shared types for the burst arbiter:
// FSM state encoding and round-robin index width helper.
package xarbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xarbiter_if.sv
// Requester/master bus bundle for xarbiter.
// slave = arbiter view, master = environment view.
interface xarbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  localparam int SW = DATA_W / 8;

  logic [N_REQ-1:0]        s_valid_i;
  logic [N_REQ-1:0]        s_ready_o;
  logic [N_REQ-1:0]        s_last_o;
  logic [ADDR_W*N_REQ-1:0] s_addr_i;
  logic [DATA_W*N_REQ-1:0] s_wdata_i;
  logic [SW*N_REQ-1:0]     s_wstrb_i;
  logic [LEN_W*N_REQ-1:0]  s_len_i;
  logic [DATA_W-1:0]       s_rdata_o;

  logic              m_valid_o;
  logic              m_ready_i;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic [SW-1:0]     m_wstrb_o;
  logic [LEN_W-1:0]  m_len_o;
  logic [DATA_W-1:0] m_rdata_i;
  logic              m_last_i;

  modport slave (
    input  s_valid_i, s_addr_i, s_wdata_i,
    input  s_wstrb_i, s_len_i,
    input  m_ready_i, m_rdata_i, m_last_i,
    output s_ready_o, s_last_o, s_rdata_o,
    output m_valid_o, m_addr_o, m_wdata_o,
    output m_wstrb_o, m_len_o
  );

  modport master (
    output s_valid_i, s_addr_i, s_wdata_i,
    output s_wstrb_i, s_len_i,
    output m_ready_i, m_rdata_i, m_last_i,
    input  s_ready_o, s_last_o, s_rdata_o,
    input  m_valid_o, m_addr_o, m_wdata_o,
    input  m_wstrb_o, m_len_o
  );

endinterface

// File: rtl/xarbiter_rr_pick.sv
// Round-robin search: first set request above last_winner, wrapping.
module xarbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_winner,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(last_winner) + i) % N_REQ;
      if (!any && req[j[IW-1:0]]) begin
        any = 1'b1;
        idx = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/xarbiter.sv
// N-way round-robin burst arbiter onto one master port.
// XARBITER_BEAT_COUNT_EN: burst end from len counter, else from m_last_i.
module xarbiter
  import xarbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  xarbiter_if.slave        bus,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o
);

  localparam int IW = clog2(N_REQ);

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] lw_q, lw_d;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          m_valid;
  logic          xfer;
  logic          last_beat;
  logic          last_flag;
  int            gi;

  xarbiter_rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req        (bus.s_valid_i),
    .last_winner(lw_q),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  assign gi     = int'(gnt_q);
  assign busy_o = (state_q == BURST);
  assign xfer   = m_valid && bus.m_ready_i;

  assign bus.s_rdata_o = bus.m_rdata_i;
  assign bus.m_valid_o = m_valid;

`ifdef XARBITER_BEAT_COUNT_EN
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             unused_m_last;
  int               pi;

  assign pi            = int'(pick_idx);
  assign unused_m_last = bus.m_last_i;
  assign last_beat     = (cnt_q == '0);
  assign last_flag     = m_valid && last_beat;
`else
  assign last_beat = bus.m_last_i;
  assign last_flag = bus.m_last_i;
`endif

  always_comb begin
    m_valid       = 1'b0;
    grant_o       = '0;
    bus.s_ready_o = '0;
    bus.s_last_o  = '0;
    bus.m_addr_o  = '0;
    bus.m_wdata_o = '0;
    bus.m_wstrb_o = '0;
    bus.m_len_o   = '0;
    if (state_q == BURST) begin
      grant_o[gnt_q]       = 1'b1;
      m_valid              = bus.s_valid_i[gnt_q];
      bus.s_ready_o[gnt_q] = bus.m_ready_i;
      bus.s_last_o[gnt_q]  = last_flag;
      bus.m_addr_o  = bus.s_addr_i[gi*ADDR_W +: ADDR_W];
      bus.m_wdata_o = bus.s_wdata_i[gi*DATA_W +: DATA_W];
      bus.m_wstrb_o = bus.s_wstrb_i[gi*(DATA_W/8) +: DATA_W/8];
      bus.m_len_o   = bus.s_len_i[gi*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lw_d    = lw_q;
`ifdef XARBITER_BEAT_COUNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          gnt_d   = pick_idx;
`ifdef XARBITER_BEAT_COUNT_EN
          cnt_d   = bus.s_len_i[pi*LEN_W +: LEN_W];
`endif
        end
      end
      BURST: begin
        if (xfer) begin
`ifdef XARBITER_BEAT_COUNT_EN
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
`endif
          if (last_beat) begin
            state_d = IDLE;
            lw_d    = gnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      lw_q    <= IW'(N_REQ - 1);
`ifdef XARBITER_BEAT_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lw_q    <= lw_d;
`ifdef XARBITER_BEAT_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/xarbiter.md
XARBITER -- requirements
Module: xarbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-004 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-005 SHALL have ports, one per line:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- s_valid_i  in  N_REQ  per-requester request valid.
- s_ready_o  out  N_REQ  per-requester beat accepted.
- s_last_o  out  N_REQ  per-requester final beat of burst.
- s_addr_i  in  ADDR_W*N_REQ  packed burst addresses.
- s_wdata_i  in  DATA_W*N_REQ  packed write data.
- s_wstrb_i  in  (DATA_W/8)*N_REQ  packed strobes; nonzero = write.
- s_len_i  in  LEN_W*N_REQ  packed burst length, beats minus one.
- s_rdata_o  out  DATA_W  read data, broadcast to all.
- m_valid_o  out  1  master beat valid.
- m_ready_i  in  1  master beat accepted.
- m_addr_o, m_wdata_o, m_wstrb_o, m_len_o  out  ADDR_W/DATA_W/DATA_W/8/LEN_W  granted requester's fields.
- m_rdata_i  in  DATA_W  master read data.
- m_last_i  in  1  master final-beat indication.
- grant_o  out  N_REQ  one-hot current grant, zero when idle.
- busy_o  out  1  high in BURST.

Function
REQ-006 SHALL implement FSM states IDLE and BURST.
REQ-007 In IDLE with any s_valid_i high, SHALL register grant to first valid requester searching upward from (last_winner+1) mod N_REQ, wrapping; enter BURST next cycle.
REQ-008 Arbitration latency SHALL be exactly one cycle from s_valid_i high (IDLE) to m_valid_o possible.
REQ-009 SHALL latch granted s_len_i into beat counter on grant; beats = len+1; len=0 is a single-beat burst.
REQ-010 In BURST, m_valid_o SHALL equal s_valid_i[grant]; m_addr/wdata/wstrb/len SHALL mux from granted requester; all m_* outputs zero in IDLE.
REQ-011 s_ready_o[grant] SHALL equal m_ready_i in BURST; other bits zero; s_ready_o all zero in IDLE.
REQ-012 s_rdata_o SHALL equal m_rdata_i combinationally, always.
REQ-013 Transfer = m_valid_o && m_ready_i; counter SHALL decrement by one per transfer, no wrap below zero.
REQ-014 Grant SHALL be held for whole burst even if s_valid_i[grant] drops; other requests ignored until IDLE.
REQ-015 On burst-end transfer SHALL return to IDLE, clear grant_o, set last_winner=grant; one IDLE cycle mandatory between bursts.
REQ-016 s_last_o[grant] SHALL be high on the burst-end beat only (definition per Configuration).
REQ-017 Single requester continuously valid SHALL be regranted every second burst-end+1 cycle pattern (BURST, IDLE, BURST...).

Reset
REQ-018 rst_n_i low SHALL asynchronously force IDLE, grant_o=0, busy_o=0, counter=0, last_winner=N_REQ-1 (so requester 0 wins first).
REQ-019 Reset mid-burst SHALL abort burst without s_last_o pulse; all outputs zero next edge-free.

Configuration
REQ-020 Macro XARBITER_BEAT_COUNT_EN defined: burst end = transfer with counter==0; s_last_o from counter; m_last_i ignored.
REQ-021 Macro undefined: burst end = transfer with m_last_i high; s_last_o[grant]=m_last_i in BURST; counter omitted.

Structure
REQ-022 Shared package SHALL hold FSM state encoding (IDLE=0, BURST=1) and round-robin index width function clog2(N_REQ).
REQ-023 Round-robin priority search SHALL be sub-module xarbiter_rr_pick (inputs request vector, last_winner; outputs index, any).

Verification
REQ-024 Reset: rst_n_i low mid-burst (beat 2 of 4) -> grant_o=0, busy_o=0, m_valid_o=0 immediately; after release req0 valid wins.
REQ-025 Round robin: all 4 valid, len=0, m_ready_i=1 -> grant order 0,1,2,3,0, each burst 1 beat, 1 idle cycle between.
REQ-026 Burst length (COUNT_EN): req2 len=3, m_ready_i toggling 1,0 -> exactly 4 transfers, s_last_o[2] on 4th, IDLE next cycle.
REQ-027 Hold: req1 granted len=2, drop s_valid_i[1] 3 cycles while req3 valid -> grant stays 1, m_valid_o=0, req3 waits.
REQ-028 Last-driven (COUNT_EN undefined): req0 len=7, m_last_i high on beat 3 -> burst ends after 3 beats, s_last_o[0] pulse.
REQ-029 Wrap: last_winner=3, only req1 and req3 valid -> req1 granted next.
